// File: rtl/mux2_1.sv
// mux2_1: 1-bit 2:1 mux (in,sel -> out, combinational) plus clk/reset_n observation stage (out_q, saturating sel_toggles)
module mux2_1 #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       in,
  input  logic             sel,
  output logic             out,
  output logic             out_q,
  output logic [CNT_W-1:0] sel_toggles
);
  logic             sel_prev_q, sel_prev_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  assign out = (in[0] & ~sel) | (in[1] & sel) | (in[0] & in[1]);
  assign sel_toggles = cnt_q;
  always_comb begin
    sel_prev_d = sel;
    cnt_d = (sel != sel_prev_q && cnt_q != '1) ? cnt_q + CNT_W'(1) : cnt_q;
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      out_q <= 1'b0;
      sel_prev_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      out_q <= out;
      sel_prev_q <= sel_prev_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: tb/tb_mux2_1.sv
`timescale 1ps/1ps
module tb_mux2_1;
  int total = 0;
  int bad = 0;
  logic clk = 1'b0;
  always #500 clk = ~clk;

  logic       reset_n, sel, out, out_q;
  logic [1:0] in;
  logic [7:0] sel_toggles;
  mux2_1 dut (.clk(clk), .reset_n(reset_n), .in(in), .sel(sel), .out(out), .out_q(out_q), .sel_toggles(sel_toggles));

  logic       s_rst_n, s_sel, s_out, s_out_q;
  logic [1:0] s_in;
  logic [2:0] s_cnt;
  mux2_1 #(.CNT_W(3)) sat (.clk(clk), .reset_n(s_rst_n), .in(s_in), .sel(s_sel), .out(s_out), .out_q(s_out_q), .sel_toggles(s_cnt));

  // combinational-only instances: clock and reset tied low so only in/sel can matter
  logic       c_sel, c_out, c_oq;
  logic [1:0] c_in;
  logic [7:0] c_cnt;
  mux2_1 comb_i (.clk(1'b0), .reset_n(1'b0), .in(c_in), .sel(c_sel), .out(c_out), .out_q(c_oq), .sel_toggles(c_cnt));

  logic [3:0] ch_in;
  logic [1:0] ch_sel;
  logic [2:0] ch_o, ch_oq;
  logic [7:0] ch_cnt [3];
  mux2_1 m0 (.clk(1'b0), .reset_n(1'b0), .in(ch_in[1:0]), .sel(ch_sel[0]), .out(ch_o[0]), .out_q(ch_oq[0]), .sel_toggles(ch_cnt[0]));
  mux2_1 m1 (.clk(1'b0), .reset_n(1'b0), .in(ch_in[3:2]), .sel(ch_sel[0]), .out(ch_o[1]), .out_q(ch_oq[1]), .sel_toggles(ch_cnt[1]));
  mux2_1 m2 (.clk(1'b0), .reset_n(1'b0), .in(ch_o[1:0]), .sel(ch_sel[1]), .out(ch_o[2]), .out_q(ch_oq[2]), .sel_toggles(ch_cnt[2]));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_comb();
    logic [2:0] v;
    logic exp;
    for (int i = 0; i < 8; i++) begin
      v = 3'(i);
      c_sel = v[2];
      c_in = v[1:0];
      exp = v[2] ? v[1] : v[0];
      #1;
      total++;
      if (c_out !== exp) begin
        bad++;
        $display("FAIL comb sel=%0d in=%b got=%b exp=%b", v[2], v[1:0], c_out, exp);
      end
      #9;
    end
  endtask

  task automatic test_chain();
    logic [5:0] v;
    logic [3:0] d;
    logic [1:0] s;
    logic exp;
    for (int i = 0; i < 64; i++) begin
      v = 6'(i);
      d = v[3:0];
      s = v[5:4];
      ch_in = d;
      ch_sel = s;
      exp = d[s];
      #1;
      total++;
      if (ch_o[2] !== exp) begin
        bad++;
        $display("FAIL chain sel=%0d in=%b got=%b exp=%b", s, d, ch_o[2], exp);
      end
      #9;
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    in = 2'b11;
    sel = 1'b1;
    #1;
    total++;
    if (out !== 1'b1) begin bad++; $display("FAIL reset_out got=%b exp=1", out); end
    for (int i = 0; i < 2; i++) begin
      step();
      total++;
      if (out_q !== 1'b0 || sel_toggles !== 8'd0) begin
        bad++;
        $display("FAIL reset_hold out_q=%b cnt=%0d exp 0/0", out_q, sel_toggles);
      end
    end
    reset_n = 1'b1;
    step();
    total++;
    if (out_q !== 1'b1 || sel_toggles !== 8'd1) begin
      bad++;
      $display("FAIL reset_release out_q=%b cnt=%0d exp 1/1", out_q, sel_toggles);
    end
  endtask

  task automatic test_registered();
    logic exp, prev;
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    in = 2'b01;
    sel = 1'b0;
    step();
    prev = 1'b1;
    for (int i = 0; i < 5; i++) begin
      sel = ~sel;
      exp = sel ? 1'b0 : 1'b1;
      #1;
      total++;
      if (out !== exp || out_q !== prev) begin
        bad++;
        $display("FAIL reg_lag i=%0d out=%b out_q=%b exp %b/%b", i, out, out_q, exp, prev);
      end
      step();
      total++;
      if (out_q !== exp || sel_toggles !== 8'(i + 1)) begin
        bad++;
        $display("FAIL reg_edge i=%0d out_q=%b cnt=%0d exp %b/%0d", i, out_q, sel_toggles, exp, i + 1);
      end
      prev = exp;
    end
  endtask

  task automatic test_glitch_x();
    sel = 1'b0;
    #10;
    sel = 1'b1;
    step();
    total++;
    if (sel_toggles !== 8'd5) begin bad++; $display("FAIL glitch cnt got=%0d exp=5", sel_toggles); end
    in = 2'b11;
    sel = 1'bx;
    #1;
    total++;
    if (out !== 1'b1) begin bad++; $display("FAIL sel_x out got=%b exp=1", out); end
    in = 2'b00;
    #1;
    total++;
    if (out !== 1'b0) begin bad++; $display("FAIL sel_x0 out got=%b exp=0", out); end
    sel = 1'b1;
    in = 2'b11;
    step();
    total++;
    if (sel_toggles !== 8'd5 || out_q !== 1'b1) begin
      bad++;
      $display("FAIL post_x cnt=%0d out_q=%b exp 5/1", sel_toggles, out_q);
    end
  endtask

  task automatic test_mid_reset();
    sel = 1'b0;
    reset_n = 1'b0;
    #1;
    total++;
    if (sel_toggles !== 8'd5 || out_q !== 1'b1) begin
      bad++;
      $display("FAIL mid_reset_early cnt=%0d out_q=%b exp 5/1", sel_toggles, out_q);
    end
    step();
    total++;
    if (sel_toggles !== 8'd0 || out_q !== 1'b0) begin
      bad++;
      $display("FAIL mid_reset cnt=%0d out_q=%b exp 0/0", sel_toggles, out_q);
    end
    reset_n = 1'b1;
  endtask

  task automatic test_saturation();
    logic [2:0] exp;
    s_in = 2'b10;
    s_sel = 1'b0;
    s_rst_n = 1'b0;
    step();
    s_rst_n = 1'b1;
    step();
    for (int i = 0; i < 12; i++) begin
      s_sel = ~s_sel;
      step();
      exp = (i + 1 > 7) ? 3'd7 : 3'(i + 1);
      total++;
      if (s_cnt !== exp) begin
        bad++;
        $display("FAIL sat i=%0d got=%0d exp=%0d", i, s_cnt, exp);
      end
    end
    s_rst_n = 1'b0;
    step();
    total++;
    if (s_cnt !== 3'd0) begin bad++; $display("FAIL sat_reset got=%0d exp=0", s_cnt); end
  endtask

  initial begin
    c_in = 2'b00; c_sel = 1'b0; ch_in = 4'd0; ch_sel = 2'd0;
    s_in = 2'b00; s_sel = 1'b0; s_rst_n = 1'b0;
    test_comb();
    test_chain();
    test_reset();
    test_registered();
    test_glitch_x();
    test_mid_reset();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
